// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl - multi-cycle control unit for the MIPS-subset datapath.
//
// Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB and
// handshakes with a variable-latency memory through mem_ready. A wait counter
// bounds every memory access; if it runs out, the core parks in a sticky
// FAULT state. Unsupported instructions also go to FAULT.
//
// Parameters:
//   MEM_TIMEOUT  maximum wait cycles per memory access (0 disables timeout)
//   CNT_W        wait counter width (MEM_TIMEOUT must fit in CNT_W bits)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Op, Funct, Zero          instruction fields from IR, ALU zero flag
//   mem_ready                memory finishes the current access this cycle
//   PCWrite, IRWrite, IorD   PC / IR load enables, memory address select
//   MemRead, MemWrite        memory request strobes
//   RegWrite, EXTOp, ALUSrc, ARegSel, ALUOp, NPCOp, GPRSel, WDSel
//                            datapath controls, single-cycle encodings
//   state                    current FSM state (debug)
//   instr_done               pulses on the last cycle of each instruction
//   fault                    high while in FAULT
module mccpu_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       EXTOp,
   output logic       ALUSrc,
   output logic       ARegSel,
   output logic [3:0] ALUOp,
   output logic [1:0] NPCOp,
   output logic [1:0] GPRSel,
   output logic [1:0] WDSel,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV = 6'b000100;
   localparam logic [5:0] F_SRLV = 6'b000110;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_JALR = 6'b001001;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_NOR  = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_SLLV = 4'd11;
   localparam logic [3:0] ALU_SRLV = 4'd12;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       legal, is_j, is_jal, is_jr, is_jalr, is_beq, is_bne;
   logic       is_lw, is_sw, is_ialu;
   logic [3:0] dec_alu_op;
   logic       dec_ext_op, dec_alu_src, dec_areg_sel;
   logic       timeout_hit;

   // Instruction decode: same per-instruction ALU/EXT controls as the
   // single-cycle controller, plus class flags used by the sequencer.
   always_comb begin
      legal        = 1'b1;
      is_j         = 1'b0;
      is_jal       = 1'b0;
      is_jr        = 1'b0;
      is_jalr      = 1'b0;
      is_beq       = 1'b0;
      is_bne       = 1'b0;
      is_lw        = 1'b0;
      is_sw        = 1'b0;
      is_ialu      = 1'b0;
      dec_alu_op   = ALU_NOP;
      dec_ext_op   = 1'b0;
      dec_alu_src  = 1'b0;
      dec_areg_sel = 1'b0;
      case (Op)
         OP_RTYPE: begin
            case (Funct)
               F_ADD, F_ADDU: dec_alu_op = ALU_ADD;
               F_SUB, F_SUBU: dec_alu_op = ALU_SUB;
               F_AND:         dec_alu_op = ALU_AND;
               F_OR:          dec_alu_op = ALU_OR;
               F_NOR:         dec_alu_op = ALU_NOR;
               F_SLT:         dec_alu_op = ALU_SLT;
               F_SLTU:        dec_alu_op = ALU_SLTU;
               F_SLL: begin dec_alu_op = ALU_SLL; dec_areg_sel = 1'b1; end
               F_SRL: begin dec_alu_op = ALU_SRL; dec_areg_sel = 1'b1; end
               F_SRA: begin dec_alu_op = ALU_SRA; dec_areg_sel = 1'b1; end
               F_SLLV:        dec_alu_op = ALU_SLLV;
               F_SRLV:        dec_alu_op = ALU_SRLV;
               F_JR:          is_jr = 1'b1;
               F_JALR:        is_jalr = 1'b1;
               default:       legal = 1'b0;
            endcase
         end
         OP_ADDI: begin dec_alu_op = ALU_ADD; dec_ext_op = 1'b1; dec_alu_src = 1'b1; is_ialu = 1'b1; end
         OP_ORI:  begin dec_alu_op = ALU_OR;  dec_alu_src = 1'b1; is_ialu = 1'b1; end
         OP_SLTI: begin dec_alu_op = ALU_SLT; dec_ext_op = 1'b1; dec_alu_src = 1'b1; is_ialu = 1'b1; end
         OP_LW:   begin dec_alu_op = ALU_ADD; dec_ext_op = 1'b1; dec_alu_src = 1'b1; is_lw = 1'b1; end
         OP_SW:   begin dec_alu_op = ALU_ADD; dec_ext_op = 1'b1; dec_alu_src = 1'b1; is_sw = 1'b1; end
         OP_BEQ:  begin dec_alu_op = ALU_SUB; dec_ext_op = 1'b1; is_beq = 1'b1; end
         OP_BNE:  begin dec_alu_op = ALU_SUB; dec_ext_op = 1'b1; is_bne = 1'b1; end
         OP_J:    is_j = 1'b1;
         OP_JAL:  is_jal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // The boundary cycle is the one where the counter already equals the
   // limit; mem_ready on that cycle still completes the access.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q >= TIMEOUT_CNT);

   // Next-state and output logic. Strobes stay constant while waiting on
   // memory because they depend only on state and the decoded instruction.
   always_comb begin
      state_d    = state_q;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      EXTOp      = 1'b0;
      ALUSrc     = 1'b0;
      ARegSel    = 1'b0;
      ALUOp      = ALU_NOP;
      NPCOp      = NPC_PLUS4;
      GPRSel     = 2'b00;
      WDSel      = 2'b00;
      instr_done = 1'b0;
      fault      = 1'b0;

      if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         ALUOp   = dec_alu_op;
         EXTOp   = dec_ext_op;
         ALUSrc  = dec_alu_src;
         ARegSel = dec_areg_sel;
      end

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            if (!legal) begin
               state_d = S_FAULT;
            end else if (is_j || is_jal || is_jr || is_jalr) begin
               PCWrite    = 1'b1;
               NPCOp      = (is_jr || is_jalr) ? NPC_JR : NPC_JUMP;
               instr_done = 1'b1;
               state_d    = S_FETCH;
               if (is_jal || is_jalr) begin
                  RegWrite = 1'b1;
                  GPRSel   = 2'b10;
                  WDSel    = 2'b10;
               end
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_beq || is_bne) begin
               PCWrite    = (is_beq & Zero) | (is_bne & ~Zero);
               NPCOp      = NPC_BRANCH;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            IorD     = 1'b1;
            MemRead  = is_lw;
            MemWrite = is_sw;
            if (mem_ready) begin
               if (is_lw) begin
                  state_d = S_WB;
               end else begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            end else if (timeout_hit) begin
               state_d = S_FAULT;
            end
         end
         S_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
            if (is_lw) begin
               WDSel  = 2'b01;
               GPRSel = 2'b01;
            end else if (is_ialu) begin
               GPRSel = 2'b01;
            end
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // A reset cycle drops any in-flight request and silences all strobes.
      if (rst) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         instr_done = 1'b0;
         fault      = 1'b0;
      end
   end

   // Wait counter restarts whenever a state is entered and only advances
   // while FETCH or MEM is held waiting for mem_ready.
   always_comb begin
      cnt_d = '0;
      if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// tb_mccpu_ctrl - directed self-checking bench for mccpu_ctrl.
//
// Walks representative instructions through the controller cycle by cycle
// with hand-computed expectations, covering memory waits, branches, jumps,
// illegal instructions, reset from MEM, and the timeout boundary in FETCH
// and MEM (DUT built with MEM_TIMEOUT=4).
module tb_mccpu_ctrl;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_JR    = 6'b001000;

   logic       clk;
   logic       rst;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
   logic       EXTOp, ALUSrc, ARegSel;
   logic [3:0] ALUOp;
   logic [1:0] NPCOp, GPRSel, WDSel;
   logic [2:0] state;
   logic       instr_done, fault;

   int checks;
   int failures;

   mccpu_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc),
      .ARegSel(ARegSel), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel),
      .WDSel(WDSel), .state(state), .instr_done(instr_done), .fault(fault)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                input logic z, input logic rdy);
      Op        = op;
      Funct     = funct;
      Zero      = z;
      mem_ready = rdy;
      #1;
   endtask

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One-cycle synchronous reset.
   task automatic pulseReset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(OP_R, F_ADD, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst.state",    8'(state),      8'd0);
      checkOutput("rst.pcwrite",  8'(PCWrite),    8'd0);
      checkOutput("rst.regwrite", 8'(RegWrite),   8'd0);
      checkOutput("rst.done",     8'(instr_done), 8'd0);
      checkOutput("rst.fault",    8'(fault),      8'd0);
      rst = 1'b0;

      // add, memory always ready: FETCH DECODE EXEC WB
      applyStimulus(OP_R, F_ADD, 1'b0, 1'b1);
      checkOutput("add.f.state",   8'(state),    8'd0);
      checkOutput("add.f.irwrite", 8'(IRWrite),  8'd1);
      checkOutput("add.f.pcwrite", 8'(PCWrite),  8'd1);
      checkOutput("add.f.npcop",   8'(NPCOp),    8'd0);
      checkOutput("add.f.memread", 8'(MemRead),  8'd1);
      checkOutput("add.f.iord",    8'(IorD),     8'd0);
      checkOutput("add.f.regwr",   8'(RegWrite), 8'd0);
      tick();
      checkOutput("add.d.state",   8'(state),    8'd1);
      checkOutput("add.d.aluop",   8'(ALUOp),    8'd1);
      checkOutput("add.d.regwr",   8'(RegWrite), 8'd0);
      tick();
      checkOutput("add.e.state",   8'(state),      8'd2);
      checkOutput("add.e.regwr",   8'(RegWrite),   8'd0);
      checkOutput("add.e.done",    8'(instr_done), 8'd0);
      tick();
      checkOutput("add.w.state",   8'(state),      8'd4);
      checkOutput("add.w.regwr",   8'(RegWrite),   8'd1);
      checkOutput("add.w.gprsel",  8'(GPRSel),     8'd0);
      checkOutput("add.w.wdsel",   8'(WDSel),      8'd0);
      checkOutput("add.w.aluop",   8'(ALUOp),      8'd1);
      checkOutput("add.w.done",    8'(instr_done), 8'd1);
      tick();
      checkOutput("add.end.state", 8'(state),      8'd0);
      checkOutput("add.end.done",  8'(instr_done), 8'd0);

      // lw: 3 wait cycles in FETCH, 2 in MEM -> 10 cycles
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
         checkOutput("lw.fw.state",   8'(state),   8'd0);
         checkOutput("lw.fw.memread", 8'(MemRead), 8'd1);
         checkOutput("lw.fw.irwrite", 8'(IRWrite), 8'd0);
         tick();
      end
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      checkOutput("lw.f.irwrite", 8'(IRWrite), 8'd1);
      tick();
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
      checkOutput("lw.d.state", 8'(state), 8'd1);
      tick();
      checkOutput("lw.e.state",  8'(state),  8'd2);
      checkOutput("lw.e.alusrc", 8'(ALUSrc), 8'd1);
      checkOutput("lw.e.extop",  8'(EXTOp),  8'd1);
      checkOutput("lw.e.aluop",  8'(ALUOp),  8'd1);
      tick();
      for (int i = 0; i < 2; i++) begin
         checkOutput("lw.mw.state",   8'(state),    8'd3);
         checkOutput("lw.mw.iord",    8'(IorD),     8'd1);
         checkOutput("lw.mw.memread", 8'(MemRead),  8'd1);
         checkOutput("lw.mw.memwr",   8'(MemWrite), 8'd0);
         tick();
      end
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      checkOutput("lw.m.state", 8'(state),      8'd3);
      checkOutput("lw.m.done",  8'(instr_done), 8'd0);
      tick();
      checkOutput("lw.w.state",  8'(state),      8'd4);
      checkOutput("lw.w.wdsel",  8'(WDSel),      8'd1);
      checkOutput("lw.w.gprsel", 8'(GPRSel),     8'd1);
      checkOutput("lw.w.regwr",  8'(RegWrite),   8'd1);
      checkOutput("lw.w.done",   8'(instr_done), 8'd1);
      tick();
      checkOutput("lw.end.state", 8'(state), 8'd0);

      // beq taken (Zero=1), beq not taken (Zero=0), bne taken (Zero=0)
      for (int k = 0; k < 3; k++) begin
         logic [5:0] bop;
         logic       zexec;
         logic [7:0] expPc;
         bop   = (k == 2) ? OP_BNE : OP_BEQ;
         zexec = (k == 0);
         expPc = (k == 1) ? 8'd0 : 8'd1;
         applyStimulus(bop, 6'd0, 1'b0, 1'b1);
         tick();
         applyStimulus(bop, 6'd0, ~zexec, 1'b0);
         checkOutput("br.d.state",   8'(state),   8'd1);
         checkOutput("br.d.pcwrite", 8'(PCWrite), 8'd0);
         tick();
         applyStimulus(bop, 6'd0, zexec, 1'b0);
         checkOutput("br.e.state",   8'(state),      8'd2);
         checkOutput("br.e.pcwrite", 8'(PCWrite),    expPc);
         checkOutput("br.e.aluop",   8'(ALUOp),      8'd2);
         checkOutput("br.e.done",    8'(instr_done), 8'd1);
         if (k == 0)
            checkOutput("br.e.npcop", 8'(NPCOp), 8'd1);
         tick();
         checkOutput("br.end.state", 8'(state), 8'd0);
      end

      // jal: 2 cycles, link in DECODE
      applyStimulus(OP_JAL, 6'd0, 1'b0, 1'b1);
      tick();
      applyStimulus(OP_JAL, 6'd0, 1'b0, 1'b0);
      checkOutput("jal.d.state",   8'(state),      8'd1);
      checkOutput("jal.d.regwr",   8'(RegWrite),   8'd1);
      checkOutput("jal.d.gprsel",  8'(GPRSel),     8'd2);
      checkOutput("jal.d.wdsel",   8'(WDSel),      8'd2);
      checkOutput("jal.d.npcop",   8'(NPCOp),      8'd2);
      checkOutput("jal.d.pcwrite", 8'(PCWrite),    8'd1);
      checkOutput("jal.d.done",    8'(instr_done), 8'd1);
      tick();
      checkOutput("jal.end.state", 8'(state), 8'd0);

      // jr: 2 cycles, no link
      applyStimulus(OP_R, F_JR, 1'b0, 1'b1);
      tick();
      checkOutput("jr.d.npcop",   8'(NPCOp),    8'd3);
      checkOutput("jr.d.regwr",   8'(RegWrite), 8'd0);
      checkOutput("jr.d.pcwrite", 8'(PCWrite),  8'd1);
      tick();
      checkOutput("jr.end.state", 8'(state), 8'd0);

      // sw: 4 cycles, write strobe in MEM
      applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("sw.e.state", 8'(state), 8'd2);
      tick();
      checkOutput("sw.m.state",   8'(state),      8'd3);
      checkOutput("sw.m.memwr",   8'(MemWrite),   8'd1);
      checkOutput("sw.m.memread", 8'(MemRead),    8'd0);
      checkOutput("sw.m.iord",    8'(IorD),       8'd1);
      checkOutput("sw.m.done",    8'(instr_done), 8'd1);
      tick();
      checkOutput("sw.end.state", 8'(state), 8'd0);

      // ori: zero-extended immediate, writes rt
      applyStimulus(OP_ORI, 6'd0, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("ori.e.aluop",  8'(ALUOp),  8'd4);
      checkOutput("ori.e.extop",  8'(EXTOp),  8'd0);
      checkOutput("ori.e.alusrc", 8'(ALUSrc), 8'd1);
      tick();
      checkOutput("ori.w.gprsel", 8'(GPRSel),   8'd1);
      checkOutput("ori.w.wdsel",  8'(WDSel),    8'd0);
      checkOutput("ori.w.regwr",  8'(RegWrite), 8'd1);
      tick();

      // sll: shift amount feeds ALU A
      applyStimulus(OP_R, F_SLL, 1'b0, 1'b1);
      tick();
      checkOutput("sll.d.aregsel", 8'(ARegSel), 8'd1);
      checkOutput("sll.d.aluop",   8'(ALUOp),   8'd8);
      tick();
      tick();
      checkOutput("sll.w.state", 8'(state), 8'd4);
      tick();

      // Illegal opcode: FAULT on cycle 3, held for 20 cycles
      applyStimulus(OP_BAD, 6'd0, 1'b0, 1'b1);
      tick();
      checkOutput("ill.d.state",   8'(state),   8'd1);
      checkOutput("ill.d.pcwrite", 8'(PCWrite), 8'd0);
      tick();
      checkOutput("ill.state",   8'(state),   8'd7);
      checkOutput("ill.fault",   8'(fault),   8'd1);
      checkOutput("ill.memread", 8'(MemRead), 8'd0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(OP_BAD, 6'd0, 1'(i % 2), 1'(i % 2));
         checkOutput("ill.hold.state", 8'(state), 8'd7);
         checkOutput("ill.hold.fault", 8'(fault), 8'd1);
         tick();
      end
      pulseReset();
      applyStimulus(OP_R, F_ADD, 1'b0, 1'b0);
      checkOutput("ill.rst.state", 8'(state), 8'd0);
      checkOutput("ill.rst.fault", 8'(fault), 8'd0);

      // Illegal funct under R-type
      applyStimulus(OP_R, 6'b111111, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("illf.state", 8'(state), 8'd7);
      pulseReset();

      // Reset while waiting in MEM drops the request
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
      checkOutput("rmem.state", 8'(state), 8'd3);
      pulseReset();
      checkOutput("rmem.rst.state", 8'(state), 8'd0);
      checkOutput("rmem.rst.iord",  8'(IorD),  8'd0);

      // FETCH timeout: 4 wait cycles tolerated, 5th non-ready cycle faults
      applyStimulus(OP_R, F_ADD, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("tof.wait.state", 8'(state), 8'd0);
         tick();
      end
      checkOutput("tof.bound.state", 8'(state), 8'd0);
      checkOutput("tof.bound.fault", 8'(fault), 8'd0);
      tick();
      checkOutput("tof.state", 8'(state), 8'd7);
      checkOutput("tof.fault", 8'(fault), 8'd1);
      pulseReset();

      // mem_ready exactly on the boundary cycle wins
      applyStimulus(OP_R, F_ADD, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(OP_R, F_ADD, 1'b0, 1'b1);
      checkOutput("tob.irwrite", 8'(IRWrite), 8'd1);
      checkOutput("tob.fault",   8'(fault),   8'd0);
      tick();
      checkOutput("tob.state", 8'(state), 8'd1);
      pulseReset();

      // MEM timeout on a store
      applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("tom.wait.state", 8'(state),    8'd3);
         checkOutput("tom.wait.memwr", 8'(MemWrite), 8'd1);
         tick();
      end
      checkOutput("tom.bound.state", 8'(state), 8'd3);
      tick();
      checkOutput("tom.state", 8'(state), 8'd7);
      checkOutput("tom.fault", 8'(fault), 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/mccpu_ctrl.md
# mccpu_ctrl

Multi-cycle control unit for the MIPS-subset datapath. It replaces the single-cycle decoder with a state machine that sequences FETCH/DECODE/EXEC/MEM/WB and handshakes with a variable-latency memory. A parametrised timeout stops the core in a sticky FAULT state when memory stalls too long. Datapath control encodings (ALUOp, NPCOp, GPRSel, WDSel) are unchanged, so ALU, NPC, EXT and RF connect unmodified.

## Interface
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready per access; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^CNT_W.
- clk  in  1  clock; all state changes occur on its rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- Op  in  6  opcode from the instruction register (IR).
- Funct  in  6  funct field from IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- MemRead / MemWrite  out  1 each  memory request strobes.
- RegWrite, EXTOp, ALUSrc, ARegSel  out  1 each  same meaning as the single-cycle controller.
- ALUOp  out  4  ALU_NOP 0000 … ALU_SRLV 1100, same encoding as the single-cycle controller.
- NPCOp  out  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR.
- GPRSel  out  2  00 rd, 01 rt, 10 $31.
- WDSel  out  2  00 ALU, 01 MEM, 10 PC.
- state  out  3  current state, for debug.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- fault  out  1  high in FAULT: illegal instruction or memory timeout.

## Operation
- State encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, FAULT 7. Codes 5 and 6 return to FETCH.
- Outputs are combinational from state, Op, Funct, Zero and mem_ready. Every strobe not listed for a state is 0.
- Supported instruction set is the same as the single-cycle controller:
  - R-type: add, sub, and, or, slt, sltu, addu, subu, nor, sll, srl, sra, sllv, srlv, jr, jalr.
  - I-type and J-type: addi, ori, slti, lw, sw, beq, bne, j, jal.
- ALUOp, EXTOp, ALUSrc and ARegSel are derived per instruction exactly as in the single-cycle controller. They are driven in every state except FETCH and FAULT.
- FETCH:
  - Drives MemRead=1, IorD=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1, NPCOp=PLUS4, go to DECODE.
- DECODE:
  - Unsupported Op/Funct: go to FAULT.
  - j: PCWrite=1, NPCOp=JUMP, go to FETCH.
  - jal: as j, plus RegWrite=1, GPRSel=10, WDSel=10.
  - jr: PCWrite=1, NPCOp=JR, go to FETCH.
  - jalr: as jr, plus RegWrite=1, GPRSel=10, WDSel=10.
  - Anything else: go to EXEC.
- EXEC:
  - beq/bne: PCWrite = (beq&Zero)|(bne&~Zero), NPCOp=BRANCH, go to FETCH.
  - lw/sw: go to MEM.
  - Others: go to WB.
- MEM:
  - Drives IorD=1; MemRead=1 for lw, MemWrite=1 for sw.
  - When mem_ready=1: lw goes to WB; sw goes to FETCH.
- WB:
  - RegWrite=1, then go to FETCH.
  - lw: WDSel=01, GPRSel=01.
  - addi/ori/slti: WDSel=00, GPRSel=01.
  - R-type: WDSel=00, GPRSel=00.
- instr_done is high on the cycle that transitions to FETCH.
- FAULT: sticky until rst. All strobes 0, fault=1.

## Timing
- Reset: state=FETCH, wait counter=0, instr_done=0, fault=0, all write strobes 0. Reset overrides any state, including mid-MEM; an in-flight memory request is dropped.
- Wait counter: clears on entry to FETCH or MEM and increments each cycle mem_ready=0. If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while mem_ready=0, the next state is FAULT. mem_ready=1 on the boundary cycle wins over the timeout.
- Latency with mem_ready tied high, in cycles: j/jal/jr/jalr 2, beq/bne 3, sw 4, R-type and I-type ALU 4, lw 5. Each wait cycle adds 1 to the access it occurs in.
- Strobes are held stable for the whole wait. mem_ready outside FETCH and MEM is ignored.
- Zero is sampled in the EXEC cycle only.

## Test plan
- Reset, then add with mem_ready=1 -> states 0,1,2,4,0. RegWrite=1 only in WB, ALUOp=0001, GPRSel=00, instr_done pulses at cycle 4.
- lw with 3 wait cycles in FETCH and 2 in MEM -> 10 cycles total. MemRead is held throughout each wait, IorD=1 in MEM, WDSel=01 in WB.
- beq with Zero=1, then Zero=0 -> PCWrite=1 and NPCOp=01 in EXEC for the first only. Both finish in 3 cycles.
- jal -> 2 cycles. In DECODE: RegWrite=1, GPRSel=10, WDSel=10, NPCOp=10.
- Op=6'b111111 -> FAULT at cycle 3 with fault=1, held 20 cycles. Then rst -> FETCH with fault=0.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 wait cycles. Repeat with mem_ready=1 exactly on the boundary cycle -> DECODE, no fault.
